// File: rtl/alk_alu_field_seq.sv
// ALK ALU micro-op field generator: expands one MUL/DIV/BCD/LIT command into a
// registered per-cycle stream of 4-bit ALU codes plus LONG_LIT, ending in a done pulse.
module alk_alu_field_seq #(
  parameter int          CNT_W       = 5,
  parameter logic [3:0]  ALU_NOP     = 4'b1000,
  parameter logic [3:0]  ALU_SUB_SL  = 4'b0011,
  parameter logic [3:0]  ALU_ADD     = 4'b0100,
  parameter logic [3:0]  ALU_ADD_BCD = 4'b0101,
  parameter logic [3:0]  ALU_ADD_SR  = 4'b0110,
  parameter logic [3:0]  ALU_ADD_SL  = 4'b0111,
  parameter logic [3:0]  ALU_PASS_SR = 4'b1010
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             req_valid_h,
  input  logic [1:0]       req_op_h,
  input  logic [CNT_W-1:0] req_cnt_h,
  output logic             ready_h,
  input  logic             stall_l,
  input  logic             abort_h,
  input  logic             mul_bit_h,
  input  logic             alu_n_h,
  output logic [3:0]       alu_h,
  output logic             long_lit_l,
  output logic             valid_h,
  output logic             done_h
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_FIX, S_DONE} state_t;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_BCD = 2'd2;
  localparam logic [1:0] OP_LIT = 2'd3;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       alu_q, alu_d;
  logic             lit_q, lit_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      alu_q   <= ALU_NOP;
      lit_q   <= 1'b1;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      lit_q   <= lit_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    alu_d   = alu_q;
    lit_d   = lit_q;
    vld_d   = vld_q;
    done_d  = done_q;
    if (abort_h) begin
      state_d = S_IDLE;
      alu_d   = ALU_NOP;
      lit_d   = 1'b1;
      vld_d   = 1'b0;
      done_d  = 1'b0;
    end else if (stall_l) begin
      unique case (state_q)
        S_IDLE: begin
          done_d = 1'b0;
          if (req_valid_h) begin
            op_d    = req_op_h;
            // A literal is a single live cycle regardless of the requested count.
            cnt_d   = (req_op_h == OP_LIT) ? '0 : req_cnt_h;
            state_d = S_STEP;
            vld_d   = 1'b1;
            lit_d   = 1'b1;
            unique case (req_op_h)
              OP_MUL: alu_d = mul_bit_h ? ALU_ADD_SR : ALU_PASS_SR;
              OP_DIV: alu_d = ALU_SUB_SL;
              OP_BCD: alu_d = ALU_ADD_BCD;
              default: begin
                alu_d = 4'b0000;
                lit_d = 1'b0;
              end
            endcase
          end
        end
        S_STEP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            unique case (op_q)
              OP_MUL:  alu_d = mul_bit_h ? ALU_ADD_SR : ALU_PASS_SR;
              OP_DIV:  alu_d = alu_n_h ? ALU_ADD_SL : ALU_SUB_SL;
              default: alu_d = ALU_ADD_BCD;
            endcase
          end else if (op_q == OP_DIV) begin
            // Restore step: only add back when the last subtract went negative.
            state_d = S_FIX;
            alu_d   = alu_n_h ? ALU_ADD : ALU_NOP;
          end else begin
            state_d = S_DONE;
            alu_d   = ALU_NOP;
            lit_d   = 1'b1;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
        S_FIX: begin
          state_d = S_DONE;
          alu_d   = ALU_NOP;
          lit_d   = 1'b1;
          vld_d   = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign ready_h    = (state_q == S_IDLE);
  assign alu_h      = alu_q;
  assign long_lit_l = lit_q;
  assign valid_h    = vld_q;
  assign done_h     = done_q;

endmodule

// File: tb/tb_alk_alu_field_seq.sv
// Scoreboard bench for alk_alu_field_seq: a command-level model queues expected
// codes per live step; a monitor pops them on every unstalled live cycle.
module tb_alk_alu_field_seq;

  logic       clk_h, reset_l, req_valid_h, stall_l, abort_h, mul_bit_h, alu_n_h;
  logic [1:0] req_op_h;
  logic [4:0] req_cnt_h;
  logic       ready_h, long_lit_l, valid_h, done_h;
  logic [3:0] alu_h;

  alk_alu_field_seq dut (
    .clk_h(clk_h), .reset_l(reset_l), .req_valid_h(req_valid_h), .req_op_h(req_op_h),
    .req_cnt_h(req_cnt_h), .ready_h(ready_h), .stall_l(stall_l), .abort_h(abort_h),
    .mul_bit_h(mul_bit_h), .alu_n_h(alu_n_h), .alu_h(alu_h), .long_lit_l(long_lit_l),
    .valid_h(valid_h), .done_h(done_h)
  );

  initial clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  bit         bseq[64];
  logic [4:0] exp_q[$];   // {alu, long_lit_l} per live step
  int         done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Samples at negedge; a live step or done pulse is consumed only by an unstalled edge.
  task automatic monitor();
    logic [4:0] e;
    forever begin
      @(negedge clk_h);
      if (mon_en && reset_l) begin
        chk("ready_vs_idle", ready_h, !valid_h && !done_h);
        if (!valid_h) chk("idle_code", {alu_h, long_lit_l}, {4'b1000, 1'b1});
        if (valid_h && stall_l && !abort_h) begin
          if (exp_q.size() == 0) chk("unexpected_step", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("step_code", {alu_h, long_lit_l}, e);
          end
        end
        if (done_h && stall_l && !abort_h) begin
          chk("done_steps_left", exp_q.size(), 0);
          if (done_q.size() == 0) chk("unexpected_done", 1, 0);
          else void'(done_q.pop_front());
        end
      end
    end
  endtask

  // Model: expected codes from the command rules, bseq[k] = select bit seen at k-th edge.
  task automatic run_cmd(input int op, input int cnt, input int stall_pct, input int force_at);
    int  live, k, cyc;
    bit  st;
    case (op)
      0: begin
        for (int i = 0; i <= cnt; i++) exp_q.push_back({bseq[i] ? 4'b0110 : 4'b1010, 1'b1});
        live = cnt + 1;
      end
      1: begin
        exp_q.push_back({4'b0011, 1'b1});
        for (int i = 1; i <= cnt; i++) exp_q.push_back({bseq[i] ? 4'b0111 : 4'b0011, 1'b1});
        exp_q.push_back({bseq[cnt+1] ? 4'b0100 : 4'b1000, 1'b1});
        live = cnt + 2;
      end
      2: begin
        for (int i = 0; i <= cnt; i++) exp_q.push_back({4'b0101, 1'b1});
        live = cnt + 1;
      end
      default: begin
        exp_q.push_back({4'b0000, 1'b0});
        live = 1;
      end
    endcase
    done_q.push_back(1);
    req_valid_h = 1'b1; req_op_h = 2'(op); req_cnt_h = 5'(cnt);
    stall_l = 1'b1; mul_bit_h = bseq[0]; alu_n_h = bseq[0];
    @(posedge clk_h); #1;
    req_valid_h = 1'b0; req_op_h = 2'($urandom); req_cnt_h = 5'($urandom);
    k = 1; cyc = 0;
    while (k <= live + 1) begin
      st = (cyc == force_at) || (int'($urandom_range(0, 99)) < stall_pct);
      stall_l = !st;
      if (st) begin
        mul_bit_h = 1'($urandom); alu_n_h = 1'($urandom);
      end else begin
        mul_bit_h = bseq[k]; alu_n_h = bseq[k];
      end
      @(posedge clk_h); #1;
      if (!st) k++;
      cyc++;
    end
    stall_l = 1'b1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) bseq[i] = 1'($urandom);
  endtask

  initial begin
    int op, cnt;
    reset_l = 1'b0; req_valid_h = 1'b0; req_op_h = 2'd0; req_cnt_h = 5'd0;
    stall_l = 1'b1; abort_h = 1'b0; mul_bit_h = 1'b0; alu_n_h = 1'b0;
    fork monitor(); join_none
    #12;
    chk("rst_alu", alu_h, 4'b1000);
    chk("rst_lit", long_lit_l, 1'b1);
    chk("rst_valid", valid_h, 1'b0);
    chk("rst_done", done_h, 1'b0);
    chk("rst_ready", ready_h, 1'b1);
    @(negedge clk_h); reset_l = 1'b1;
    @(posedge clk_h); #1;
    mon_en = 1'b1;

    // Directed command shapes through the scoreboard
    bseq[0] = 1; bseq[1] = 0; bseq[2] = 1; bseq[3] = 1; bseq[4] = 0;
    run_cmd(0, 3, 0, -1);
    bseq[0] = 0; bseq[1] = 0; bseq[2] = 1; bseq[3] = 1;
    run_cmd(1, 1, 0, -1);
    run_cmd(3, 9, 0, -1);
    run_cmd(2, 2, 0, 1);
    fill_rand(); run_cmd(0, 31, 0, -1);
    fill_rand(); run_cmd(1, 31, 10, -1);

    for (int n = 0; n < 40; n++) begin
      fill_rand();
      op  = int'($urandom_range(0, 3));
      cnt = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 6));
      run_cmd(op, cnt, 20, -1);
    end
    repeat (3) @(posedge clk_h);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_all_seen", done_q.size(), 0);
    mon_en = 1'b0;

    // Abort mid-DIV, asserted together with a stall to show abort wins
    req_valid_h = 1'b1; req_op_h = 2'd1; req_cnt_h = 5'd5; alu_n_h = 1'b0;
    @(posedge clk_h); #1; req_valid_h = 1'b0;
    @(posedge clk_h); #1;
    chk("abort_pre_valid", valid_h, 1'b1);
    chk("abort_pre_alu", alu_h, 4'b0011);
    abort_h = 1'b1; stall_l = 1'b0;
    @(posedge clk_h); #1;
    abort_h = 1'b0; stall_l = 1'b1;
    chk("abort_alu", alu_h, 4'b1000);
    chk("abort_valid", valid_h, 1'b0);
    chk("abort_ready", ready_h, 1'b1);
    chk("abort_lit", long_lit_l, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", done_h, 1'b0);
      @(posedge clk_h); #1;
    end

    // Async reset in the middle of a MUL
    req_valid_h = 1'b1; req_op_h = 2'd0; req_cnt_h = 5'd5; mul_bit_h = 1'b1;
    @(posedge clk_h); #1; req_valid_h = 1'b0;
    @(posedge clk_h); #2;
    chk("mid_mul_alu", alu_h, 4'b0110);
    reset_l = 1'b0; #1;
    chk("arst_alu", alu_h, 4'b1000);
    chk("arst_valid", valid_h, 1'b0);
    chk("arst_ready", ready_h, 1'b1);
    chk("arst_lit", long_lit_l, 1'b1);
    @(negedge clk_h); reset_l = 1'b1;
    @(posedge clk_h); #1;
    chk("arst_stays_idle", valid_h, 1'b0);

    // Literal, then a request held through DONE must not be taken
    req_valid_h = 1'b1; req_op_h = 2'd3;
    @(posedge clk_h); #1;
    chk("lit_alu", alu_h, 4'b0000);
    chk("lit_lit", long_lit_l, 1'b0);
    chk("lit_valid", valid_h, 1'b1);
    req_op_h = 2'd2;
    @(posedge clk_h); #1;
    chk("lit_done", done_h, 1'b1);
    chk("done_not_ready", ready_h, 1'b0);
    @(posedge clk_h); #1;
    chk("done_req_ignored", valid_h, 1'b0);
    chk("back_idle", ready_h, 1'b1);
    stall_l = 1'b0;
    @(posedge clk_h); #1;
    chk("stalled_idle_no_accept", valid_h, 1'b0);
    req_valid_h = 1'b0; stall_l = 1'b1;
    @(posedge clk_h); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
